// File: rtl/txt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : txt_pkg
// Description : Shared definitions for the text-buffer write controller:
//               control-code byte values, controller state type, cursor
//               command type and default screen geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package txt_pkg;

    localparam int COLS_DEFAULT = 80;
    localparam int ROWS_DEFAULT = 25;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        CUR_NONE = 3'd0,
        CUR_ADV  = 3'd1,
        CUR_BACK = 3'd2,
        CUR_CR   = 3'd3,
        CUR_NL   = 3'd4,
        CUR_HOME = 3'd5
    } cur_cmd_t;

endpackage : txt_pkg
`default_nettype wire

// File: rtl/txt_cursor.sv
`default_nettype none
// ============================================================================
// Module      : txt_cursor
// Description : Cursor column/row counters plus a running row base address
//               (row*COLS kept incrementally, no multiplier). Executes one
//               command per cycle and applies column/row wrap.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               cmd           - cursor command for this cycle
//               col, row      - current cursor position (registered)
//               addr          - row_base + col, address of the current cell
// Revision    : 1.0 - initial release
// ============================================================================
module txt_cursor
    import txt_pkg::*;
#(
    parameter int COLS       = COLS_DEFAULT,
    parameter int ROWS       = ROWS_DEFAULT,
    parameter int ADDR_WIDTH = 11,
    localparam int COL_W     = $clog2(COLS),
    localparam int ROW_W     = $clog2(ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  cur_cmd_t              cmd,
    output logic [COL_W-1:0]      col,
    output logic [ROW_W-1:0]      row,
    output logic [ADDR_WIDTH-1:0] addr
);

    localparam logic [COL_W-1:0]      C_COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]      C_ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] C_ROW_STEP = ADDR_WIDTH'(COLS);

    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic                  w_newline;

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        w_newline  = 1'b0;

        case (cmd)
            CUR_ADV: begin
                if (col_q == C_COL_LAST) begin
                    col_d     = '0;
                    w_newline = 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            CUR_BACK: begin
                if (col_q != '0) begin
                    col_d = col_q - 1'b1;
                end
            end
            CUR_CR: begin
                col_d = '0;
            end
            CUR_NL: begin
                col_d     = '0;
                w_newline = 1'b1;
            end
            CUR_HOME: begin
                col_d      = '0;
                row_d      = '0;
                row_base_d = '0;
            end
            default: ;
        endcase

        // No scrolling: moving past the last row wraps to the top.
        if (w_newline) begin
            if (row_q == C_ROW_LAST) begin
                row_d      = '0;
                row_base_d = '0;
            end else begin
                row_d      = row_q + 1'b1;
                row_base_d = row_base_q + C_ROW_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign addr = row_base_q + ADDR_WIDTH'(col_q);

endmodule : txt_cursor
`default_nettype wire

// File: rtl/txt_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : txt_buf_ctrl
// Description : Character-stream controller for the text-mode RAM write
//               port. Accepts bytes on a valid/ready handshake, interprets
//               CR/LF/BS/FF, writes printable bytes at the cursor and runs a
//               full-screen clear sequence.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               in_valid/in_data      - input byte stream
//               in_ready              - byte accepted when in_valid&&in_ready
//               ram_we/waddr/wdata    - registered RAM write port
//               busy                  - clear sequence in progress
//               cursor_col/cursor_row - current cursor position
// Options     : TXT_CLEAR_ON_RESET_EN - when defined, reset starts a clear
//               sequence; otherwise reset enters IDLE ready for bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module txt_buf_ctrl
    import txt_pkg::*;
#(
    parameter int         COLS       = COLS_DEFAULT,
    parameter int         ROWS       = ROWS_DEFAULT,
    parameter int         ADDR_WIDTH = 11,
    parameter int         DATA_WIDTH = 8,
    parameter logic [7:0] FILL_CHAR  = 8'h20,
    localparam int        COL_W      = $clog2(COLS),
    localparam int        ROW_W      = $clog2(ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  busy,
    output logic [COL_W-1:0]      cursor_col,
    output logic [ROW_W-1:0]      cursor_row
);

    localparam int                    CELLS       = COLS * ROWS;
    localparam int                    CNT_W       = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]      C_CELLS     = CNT_W'(CELLS);
    localparam logic [CNT_W-1:0]      C_LAST_CELL = CNT_W'(CELLS - 1);
    localparam logic [DATA_WIDTH-1:0] C_FILL      = DATA_WIDTH'(FILL_CHAR);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      clr_cnt_q, clr_cnt_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_waddr_q, ram_waddr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;

    cur_cmd_t              w_cur_cmd;
    logic [ADDR_WIDTH-1:0] w_cur_addr;
    logic                  w_accept;

    txt_cursor #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cursor (
        .clk  (clk),
        .rst  (rst),
        .cmd  (w_cur_cmd),
        .col  (cursor_col),
        .row  (cursor_row),
        .addr (w_cur_addr)
    );

    assign w_accept = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        ram_we_d    = 1'b0;
        ram_waddr_d = ram_waddr_q;
        ram_wdata_d = ram_wdata_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        w_cur_cmd   = CUR_NONE;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (in_data == CH_CR) begin
                        w_cur_cmd = CUR_CR;
                    end else if (in_data == CH_LF) begin
                        w_cur_cmd = CUR_NL;
                    end else if (in_data == CH_BS) begin
                        // Backspace at column 0 is a no-op; otherwise the
                        // fill goes to the cell left of the cursor.
                        if (cursor_col != '0) begin
                            w_cur_cmd   = CUR_BACK;
                            ram_we_d    = 1'b1;
                            ram_waddr_d = w_cur_addr - 1'b1;
                            ram_wdata_d = C_FILL;
                        end
                    end else if (in_data == CH_FF) begin
                        state_d    = CLEAR;
                        clr_cnt_d  = '0;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                    end else begin
                        w_cur_cmd   = CUR_ADV;
                        ram_we_d    = 1'b1;
                        ram_waddr_d = w_cur_addr;
                        ram_wdata_d = DATA_WIDTH'(in_data);
                    end
                end
            end
            CLEAR: begin
                // The counter runs one past the last cell so the final write
                // cycle still shows busy=1/in_ready=0; IDLE follows after.
                if (clr_cnt_q < C_CELLS) begin
                    ram_we_d    = 1'b1;
                    ram_waddr_d = clr_cnt_q[ADDR_WIDTH-1:0];
                    ram_wdata_d = C_FILL;
                    clr_cnt_d   = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == C_LAST_CELL) begin
                        w_cur_cmd = CUR_HOME;
                    end
                end else begin
                    state_d    = IDLE;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef TXT_CLEAR_ON_RESET_EN
            state_q    <= CLEAR;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`else
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
`endif
            clr_cnt_q   <= '0;
            ram_we_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            clr_cnt_q   <= clr_cnt_d;
            ram_we_q    <= ram_we_d;
            ram_waddr_q <= ram_waddr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign ram_we    = ram_we_q;
    assign ram_waddr = ram_waddr_q;
    assign ram_wdata = ram_wdata_q;

endmodule : txt_buf_ctrl
`default_nettype wire

// File: tb/tb_txt_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_txt_buf_ctrl
// Description : Self-checking bench for txt_buf_ctrl (80x25 default build,
//               honours TXT_CLEAR_ON_RESET_EN). A screen-level model predicts
//               outputs every cycle; directed sequences add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_txt_buf_ctrl;

    localparam int COLS  = 80;
    localparam int ROWS  = 25;
    localparam int CELLS = COLS * ROWS;
    localparam int FILL  = 8'h20;
`ifdef TXT_CLEAR_ON_RESET_EN
    localparam bit CLR_ON_RST = 1'b1;
`else
    localparam bit CLR_ON_RST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        ram_we;
    logic [10:0] ram_waddr;
    logic [7:0]  ram_wdata;
    logic        busy;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    txt_buf_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .ram_we     (ram_we),
        .ram_waddr  (ram_waddr),
        .ram_wdata  (ram_wdata),
        .busy       (busy),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- screen-level model ----------------
    int m_col = 0, m_row = 0, m_idx = 0, m_addr = 0, m_data = 0;
    bit m_clr = 1'b0, m_we = 1'b0, m_adchk = 1'b0, m_started = 1'b0;

    always @(posedge clk) begin : model
        int c, r, idx, addr, data;
        bit clr, we, adchk;
        c = m_col; r = m_row; idx = m_idx; clr = m_clr;
        addr = m_addr; data = m_data; we = 1'b0; adchk = 1'b0;
        if (rst) begin
            c = 0; r = 0; addr = 0; data = 0; adchk = 1'b1;
            idx = 0; clr = CLR_ON_RST;
        end else if (clr) begin
            if (idx < CELLS) begin
                we = 1'b1; addr = idx; data = FILL; idx++;
                if (idx == CELLS) begin c = 0; r = 0; end
            end else begin
                clr = 1'b0;
            end
        end else if (in_valid) begin
            case (in_data)
                8'h0D: c = 0;
                8'h0A: begin c = 0; r = (r + 1) % ROWS; end
                8'h08: if (c > 0) begin c--; we = 1'b1; addr = r * COLS + c; data = FILL; end
                8'h0C: begin clr = 1'b1; idx = 0; end
                default: begin
                    we = 1'b1; addr = r * COLS + c; data = in_data; c++;
                    if (c == COLS) begin c = 0; r = (r + 1) % ROWS; end
                end
            endcase
        end
        m_col <= c; m_row <= r; m_idx <= idx; m_clr <= clr;
        m_we <= we; m_addr <= addr; m_data <= data; m_adchk <= adchk;
        m_started <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("m_ram_we",   ram_we,     m_we);
            chk("m_in_ready", in_ready,   !m_clr);
            chk("m_busy",     busy,       m_clr);
            chk("m_col",      cursor_col, m_col);
            chk("m_row",      cursor_row, m_row);
            if (m_we || m_adchk) begin
                chk("m_waddr", ram_waddr, m_addr);
                chk("m_wdata", ram_wdata, m_data);
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 2100 && !in_ready; i++) @(negedge clk);
        chk("wait_ready", in_ready, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        bit got;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_we",    ram_we, 0);
        chk("rst_waddr", ram_waddr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_col",   cursor_col, 0);
        chk("rst_row",   cursor_row, 0);
        chk("rst_ready", in_ready, !CLR_ON_RST);
        chk("rst_busy",  busy, CLR_ON_RST);
        rst = 1'b0;
        wait_ready();

        // First printable byte
        send(8'h41);
        chk("a_we", ram_we, 1); chk("a_addr", ram_waddr, 0); chk("a_data", ram_wdata, 8'h41);
        chk("a_col", cursor_col, 1); chk("a_row", cursor_row, 0);

        // Column wrap at end of row 0
        repeat (78) send(8'h61);
        chk("c79_col", cursor_col, 79);
        send(8'h42); chk("b_addr", ram_waddr, 79); chk("b_data", ram_wdata, 8'h42);
        send(8'h43); chk("c_addr", ram_waddr, 80); chk("c_data", ram_wdata, 8'h43);
        chk("c_col", cursor_col, 1); chk("c_row", cursor_row, 1);

        // Screen wrap at the last cell
        repeat (23) send(8'h0A);
        repeat (79) send(8'h2A);
        chk("e_col", cursor_col, 79); chk("e_row", cursor_row, 24);
        send(8'h44); chk("d_addr", ram_waddr, 1999);
        send(8'h45); chk("e_addr", ram_waddr, 0); chk("e_data", ram_wdata, 8'h45);
        chk("e_col2", cursor_col, 1); chk("e_row2", cursor_row, 0);
        idle();

        // Form feed with the next byte already waiting on the port
        send(8'h0C);
        chk("ff_ready", in_ready, 0);
        in_data = 8'h46;
        n = 0; got = 1'b0;
        for (int i = 0; i < 2100 && !got; i++) begin
            @(negedge clk);
            if (ram_we && ram_wdata == 8'h46) begin
                got = 1'b1;
                in_valid = 1'b0;
                chk("ff_next_addr", ram_waddr, 0);
            end else if (ram_we) begin
                chk("clr_addr", ram_waddr, n);
                chk("clr_data", ram_wdata, 8'h20);
                chk("clr_ready", in_ready, 0);
                n++;
            end
        end
        chk("clr_count", n, 2000);
        chk("ff_next_seen", got, 1);
        idle();

        // Backspace, CR and LF
        send(8'h0D);
        repeat (3) send(8'h0A);
        send(8'h08);
        chk("bs0_we", ram_we, 0); chk("bs0_col", cursor_col, 0); chk("bs0_row", cursor_row, 3);
        repeat (5) send(8'h58);
        send(8'h08);
        chk("bs_we", ram_we, 1); chk("bs_addr", ram_waddr, 244); chk("bs_data", ram_wdata, 8'h20);
        chk("bs_col", cursor_col, 4);
        send(8'h0D); chk("cr_we", ram_we, 0); chk("cr_col", cursor_col, 0);
        send(8'h0A); chk("lf_we", ram_we, 0); chk("lf_col", cursor_col, 0); chk("lf_row", cursor_row, 4);
        idle();

        // Reset in the middle of a clear
        send(8'h0C);
        in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 1100 && n < 1000; i++) begin
            @(negedge clk);
            if (ram_we) n++;
        end
        chk("mid_count", n, 1000);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_we", ram_we, 0);
        rst = 1'b0;
        if (CLR_ON_RST) begin
            n = 0;
            for (int i = 0; i < 2100 && !in_ready; i++) begin
                @(negedge clk);
                if (ram_we) begin
                    chk("reclr_addr", ram_waddr, n);
                    n++;
                end
            end
            chk("reclr_count", n, 2000);
        end else begin
            chk("post_rst_ready", in_ready, 1);
            chk("post_rst_busy",  busy, 0);
        end
        chk("post_col", cursor_col, 0); chk("post_row", cursor_row, 0);
        wait_ready();
        send(8'h47);
        chk("post_addr", ram_waddr, 0); chk("post_data", ram_wdata, 8'h47);
        idle();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_txt_buf_ctrl
`default_nettype wire

// File: doc/txt_buf_ctrl.md
Name: txt_buf_ctrl

Overview:
Character-stream controller for the text-mode display RAM write port. Consumes bytes over a valid/ready handshake and tracks a cursor. Interprets control codes and turns printable bytes into single-cycle RAM writes at row*COLS+col. Also runs a full-screen clear sequence. Sits between the host/UART byte source and the font display's character RAM. The read side stays owned by the video scanner.

Parameters:
COLS, 80, characters per row
ROWS, 25, rows per screen; COLS*ROWS must be <= 2**ADDR_WIDTH
ADDR_WIDTH, 11, RAM address width
DATA_WIDTH, 8, RAM data width; bytes are zero-extended if wider
FILL_CHAR, 8'h20, value written by clear and backspace

Ports:
clk  in  1  system clock
rst  in  1  reset
in_valid  in  1  input byte valid
in_data  in  8  input byte
in_ready  out  1  controller can accept in_data this cycle
ram_we  out  1  RAM write enable
ram_waddr  out  ADDR_WIDTH  RAM write address
ram_wdata  out  DATA_WIDTH  RAM write data
busy  out  1  high while the clear sequence runs
cursor_col  out  $clog2(COLS)  current column
cursor_row  out  $clog2(ROWS)  current row

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - ram_we=0, ram_waddr=0, ram_wdata=0, cursor=(0,0).
  - State and in_ready/busy depend on the optional feature.
- States: IDLE and CLEAR.
- Handshake: a byte is accepted on a clk edge with in_valid && in_ready. in_ready=1 only in IDLE. Throughput is 1 byte/cycle in IDLE.
- Write latency: ram_we is high on the cycle after acceptance, for exactly 1 cycle. Address and data are valid in that same cycle.
- Byte handling (in IDLE):
  - 0x0D (CR): col<=0. No write.
  - 0x0A (LF): col<=0, row<=row+1. No write.
  - 0x08 (BS), col>0: col<=col-1, then write FILL_CHAR at the new position.
  - 0x08 (BS), col==0: no-op, no write.
  - 0x0C (FF): enter CLEAR. in_ready drops the next cycle.
  - Any other byte: write it at the current position, then col<=col+1.
- Wrap rules:
  - col==COLS-1 advancing: col<=0, row<=row+1.
  - row==ROWS-1 advancing: row<=0. There is no scrolling.
  - Write at cell COLS*ROWS-1 followed by one more printable byte: the next write goes to address 0.
- Address generation: keep a registered row_base (row*COLS), updated by +COLS or reset to 0. Use no multiplier. ram_waddr = row_base + col.
- CLEAR:
  - Writes FILL_CHAR to addresses 0..COLS*ROWS-1, one per cycle, consecutively.
  - ram_we is high for exactly COLS*ROWS cycles. busy=1 and in_ready=0 throughout.
  - On the last write: cursor<=(0,0) and return to IDLE. in_ready=1 the cycle after the last ram_we.
- Simultaneous events: rst wins over everything. While busy, in_valid is ignored and the byte is not consumed.
- Reset mid-CLEAR: the sequence aborts immediately, with ram_we=0 on the next cycle. The controller then restarts per the optional feature.

Optional Feature:
Macro: TXT_CLEAR_ON_RESET_EN.
- Defined: reset enters CLEAR (busy=1, in_ready=0 from reset release) and wipes the screen before accepting bytes.
- Undefined: reset enters IDLE with in_ready=1 and busy=0. RAM contents are untouched.

Decomposition:
- Shared package txt_pkg holds:
  - control-code constants: CH_CR, CH_LF, CH_BS, CH_FF
  - state enum type: IDLE, CLEAR
  - COLS/ROWS defaults
- One natural sub-module, txt_cursor. It owns the col/row/row_base counters with advance/backspace/newline/home commands and wrap logic.
- txt_buf_ctrl keeps the FSM, the handshake and the RAM port drive.

Test Plan:
- Reset released (macro off), send 0x41 → 1 cycle later: ram_we=1, waddr=0, wdata=0x41. Cursor becomes (1,0).
- Cursor at (79,0), send 0x42 then 0x43 → writes at addr 79 and addr 80. Cursor ends at (1,1).
- Cursor at (79,24), send 0x44 then 0x45 → writes at addr 1999 and addr 0. Cursor ends at (1,0).
- Send 0x0C with in_valid held high and a following byte 0x46:
  - ram_we high 2000 consecutive cycles, addr 0..1999, data 0x20.
  - in_ready low throughout.
  - 0x46 is then written at addr 0.
- Cursor (0,3), send 0x08 → no write. Cursor (5,3), send 0x08 → write 0x20 at addr 244. Send 0x0D then 0x0A → no writes, cursor (0,4).
- Assert rst at clear cycle 1000 (macro on) → ram_we=0 the next cycle. After release: a full 2000-cycle clear restarts from addr 0.
